// File: rtl/uart_echo_core.sv
// uart_echo_core: UART RX deserialiser, TX FIFO and TX serialiser with optional RX->TX echo.
// Optional RTS/CTS flow control is compiled in when UART_FLOW_CTRL_EN is defined.
`timescale 1ns/1ps
module uart_echo_core #(
  parameter int unsigned SYS_CLK_FREQ = 50000000,
  parameter int unsigned BAUD_RATE    = 115200,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_AW      = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 uart_rx_i,
  output logic                 uart_tx_o,
  output logic                 uart_cts_o,
  input  logic                 uart_rts_i,
  input  logic                 echo_en_i,
  output logic                 rx_irq_o,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_perr_o,
  output logic                 rx_ferr_o,
  input  logic                 tx_irq_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  output logic                 tx_ovf_o,
  output logic [FIFO_AW:0]     tx_level_o,
  output logic                 tx_busy_o
);
  localparam int unsigned BIT_CNT = SYS_CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF    = BIT_CNT / 2;
  localparam int unsigned CW      = $clog2(BIT_CNT + 1);
  localparam int unsigned DBW     = $clog2(DATA_BITS);
  localparam int unsigned DEPTH   = 2 ** FIFO_AW;
  localparam int unsigned LW      = FIFO_AW + 1;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT_HI} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;

  function automatic logic f_parity(input logic [DATA_BITS-1:0] d);
    return (PARITY == 2) ? ^d : ~^d;
  endfunction

  logic                 r_rx_s1, r_rx_s2, r_rx_prev;
  rx_state_t            r_rx_state, w_rx_state_n;
  logic [CW-1:0]        r_rx_cnt, w_rx_cnt_n;
  logic [DBW-1:0]       r_rx_bit, w_rx_bit_n;
  logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_n, r_rx_data, w_rx_data_n;
  logic                 r_rx_par, w_rx_par_n;
  logic                 r_rx_irq, w_rx_irq_n, r_rx_perr, w_rx_perr_n, r_rx_ferr, w_rx_ferr_n;

  tx_state_t            r_tx_state, w_tx_state_n;
  logic [CW-1:0]        r_tx_cnt, w_tx_cnt_n;
  logic [DBW-1:0]       r_tx_bit, w_tx_bit_n;
  logic                 r_tx_stop, w_tx_stop_n;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_n;
  logic                 r_tx_par, w_tx_par_n, r_tx, w_tx_n;
  logic                 w_pop, w_can_pop, w_permit;

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [FIFO_AW-1:0]   r_wr_ptr, w_wr_ptr_n, r_rd_ptr, w_rd_ptr_n;
  logic [LW-1:0]        r_level, w_level_n;
  logic [DATA_BITS-1:0] w_push_data, w_rd_data;
  logic                 w_echo, w_full, w_push_req, w_push_ok;
  logic                 r_ovf, w_ovf_n, r_busy, w_busy_n, r_cts, w_cts_n;

`ifdef UART_FLOW_CTRL_EN
  assign w_permit = uart_rts_i;
  assign w_cts_n  = (w_level_n < LW'(DEPTH - 2));
`else
  logic w_unused_rts;
  assign w_unused_rts = uart_rts_i;
  assign w_permit     = 1'b1;
  assign w_cts_n      = 1'b1;
`endif

  // RX next-state: start validated at half bit, then sampled at bit centres
  always_comb begin
    w_rx_state_n = r_rx_state;
    w_rx_cnt_n   = r_rx_cnt;
    w_rx_bit_n   = r_rx_bit;
    w_rx_shift_n = r_rx_shift;
    w_rx_par_n   = r_rx_par;
    w_rx_data_n  = r_rx_data;
    w_rx_irq_n   = 1'b0;
    w_rx_perr_n  = 1'b0;
    w_rx_ferr_n  = 1'b0;
    if (r_rx_state != RX_IDLE && r_rx_state != RX_WAIT_HI) w_rx_cnt_n = r_rx_cnt + CW'(1);
    case (r_rx_state)
      RX_IDLE: if (r_rx_prev && !r_rx_s2) begin
        w_rx_state_n = RX_START;
        w_rx_cnt_n   = '0;
      end
      RX_START: if (r_rx_cnt == CW'(HALF - 1)) begin
        w_rx_cnt_n   = '0;
        w_rx_bit_n   = '0;
        w_rx_state_n = r_rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (r_rx_cnt == CW'(BIT_CNT - 1)) begin
        w_rx_cnt_n   = '0;
        w_rx_shift_n = {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
        w_rx_bit_n   = r_rx_bit + DBW'(1);
        if (r_rx_bit == DBW'(DATA_BITS - 1)) w_rx_state_n = (PARITY != 0) ? RX_PAR : RX_STOP;
      end
      RX_PAR: if (r_rx_cnt == CW'(BIT_CNT - 1)) begin
        w_rx_cnt_n   = '0;
        w_rx_par_n   = r_rx_s2;
        w_rx_state_n = RX_STOP;
      end
      RX_STOP: if (r_rx_cnt == CW'(BIT_CNT - 1)) begin
        w_rx_cnt_n = '0;
        if (!r_rx_s2) begin
          w_rx_ferr_n  = 1'b1;
          w_rx_state_n = RX_WAIT_HI;
        end else if (PARITY != 0 && r_rx_par != f_parity(r_rx_shift)) begin
          w_rx_perr_n  = 1'b1;
          w_rx_state_n = RX_IDLE;
        end else begin
          w_rx_irq_n   = 1'b1;
          w_rx_data_n  = r_rx_shift;
          w_rx_state_n = RX_IDLE;
        end
      end
      RX_WAIT_HI: if (r_rx_s2) w_rx_state_n = RX_IDLE;
      default: w_rx_state_n = RX_IDLE;
    endcase
  end

  // FIFO bookkeeping: echo has priority over the host strobe
  always_comb begin
    w_echo      = r_rx_irq && echo_en_i;
    w_full      = (r_level == LW'(DEPTH));
    w_push_req  = w_echo || tx_irq_i;
    w_push_data = w_echo ? r_rx_data : tx_data_i;
    w_push_ok   = w_push_req && (!w_full || w_pop);
    w_ovf_n     = (w_echo && tx_irq_i) || (w_push_req && !w_push_ok);
    w_wr_ptr_n  = w_push_ok ? r_wr_ptr + FIFO_AW'(1) : r_wr_ptr;
    w_rd_ptr_n  = w_pop ? r_rd_ptr + FIFO_AW'(1) : r_rd_ptr;
    w_level_n   = r_level + LW'(w_push_ok) - LW'(w_pop);
    w_rd_data   = r_mem[r_rd_ptr];
  end

  // TX next-state: the final stop bit may pop the next byte directly for gapless frames
  always_comb begin
    w_tx_state_n = r_tx_state;
    w_tx_cnt_n   = r_tx_cnt;
    w_tx_bit_n   = r_tx_bit;
    w_tx_stop_n  = r_tx_stop;
    w_tx_shift_n = r_tx_shift;
    w_tx_par_n   = r_tx_par;
    w_tx_n       = r_tx;
    w_pop        = 1'b0;
    w_can_pop    = (r_level != '0) && w_permit;
    if (r_tx_state != TX_IDLE) w_tx_cnt_n = r_tx_cnt + CW'(1);
    case (r_tx_state)
      TX_IDLE: w_pop = w_can_pop;
      TX_START: if (r_tx_cnt == CW'(BIT_CNT - 1)) begin
        w_tx_cnt_n   = '0;
        w_tx_bit_n   = '0;
        w_tx_n       = r_tx_shift[0];
        w_tx_state_n = TX_DATA;
      end
      TX_DATA: if (r_tx_cnt == CW'(BIT_CNT - 1)) begin
        w_tx_cnt_n = '0;
        if (r_tx_bit == DBW'(DATA_BITS - 1)) begin
          w_tx_stop_n  = 1'b0;
          w_tx_n       = (PARITY != 0) ? r_tx_par : 1'b1;
          w_tx_state_n = (PARITY != 0) ? TX_PAR : TX_STOP;
        end else begin
          w_tx_bit_n   = r_tx_bit + DBW'(1);
          w_tx_shift_n = {1'b0, r_tx_shift[DATA_BITS-1:1]};
          w_tx_n       = r_tx_shift[1];
        end
      end
      TX_PAR: if (r_tx_cnt == CW'(BIT_CNT - 1)) begin
        w_tx_cnt_n   = '0;
        w_tx_stop_n  = 1'b0;
        w_tx_n       = 1'b1;
        w_tx_state_n = TX_STOP;
      end
      TX_STOP: if (r_tx_cnt == CW'(BIT_CNT - 1)) begin
        w_tx_cnt_n = '0;
        if (r_tx_stop == 1'(STOP_BITS - 1)) begin
          w_pop        = w_can_pop;
          w_tx_state_n = TX_IDLE;
        end else begin
          w_tx_stop_n = 1'b1;
        end
      end
      default: w_tx_state_n = TX_IDLE;
    endcase
    if (w_pop) begin
      w_tx_shift_n = w_rd_data;
      w_tx_par_n   = f_parity(w_rd_data);
      w_tx_cnt_n   = '0;
      w_tx_n       = 1'b0;
      w_tx_state_n = TX_START;
    end
    w_busy_n = (w_tx_state_n != TX_IDLE) || (w_level_n != '0);
  end

  always_ff @(posedge clk_i) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rx_s1 <= 1'b1; r_rx_s2 <= 1'b1; r_rx_prev <= 1'b1;
      r_rx_state <= RX_IDLE; r_rx_cnt <= '0; r_rx_bit <= '0; r_rx_shift <= '0;
      r_rx_par <= 1'b0; r_rx_data <= '0; r_rx_irq <= 1'b0; r_rx_perr <= 1'b0; r_rx_ferr <= 1'b0;
      r_tx_state <= TX_IDLE; r_tx_cnt <= '0; r_tx_bit <= '0; r_tx_stop <= 1'b0;
      r_tx_shift <= '0; r_tx_par <= 1'b0; r_tx <= 1'b1;
      r_wr_ptr <= '0; r_rd_ptr <= '0; r_level <= '0;
      r_ovf <= 1'b0; r_busy <= 1'b0; r_cts <= 1'b1;
    end else begin
      r_rx_s1 <= uart_rx_i; r_rx_s2 <= r_rx_s1; r_rx_prev <= r_rx_s2;
      r_rx_state <= w_rx_state_n; r_rx_cnt <= w_rx_cnt_n; r_rx_bit <= w_rx_bit_n;
      r_rx_shift <= w_rx_shift_n; r_rx_par <= w_rx_par_n; r_rx_data <= w_rx_data_n;
      r_rx_irq <= w_rx_irq_n; r_rx_perr <= w_rx_perr_n; r_rx_ferr <= w_rx_ferr_n;
      r_tx_state <= w_tx_state_n; r_tx_cnt <= w_tx_cnt_n; r_tx_bit <= w_tx_bit_n;
      r_tx_stop <= w_tx_stop_n; r_tx_shift <= w_tx_shift_n; r_tx_par <= w_tx_par_n; r_tx <= w_tx_n;
      r_wr_ptr <= w_wr_ptr_n; r_rd_ptr <= w_rd_ptr_n; r_level <= w_level_n;
      r_ovf <= w_ovf_n; r_busy <= w_busy_n; r_cts <= w_cts_n;
    end
  end

  assign uart_tx_o  = r_tx;
  assign uart_cts_o = r_cts;
  assign rx_irq_o   = r_rx_irq;
  assign rx_data_o  = r_rx_data;
  assign rx_perr_o  = r_rx_perr;
  assign rx_ferr_o  = r_rx_ferr;
  assign tx_ovf_o   = r_ovf;
  assign tx_level_o = r_level;
  assign tx_busy_o  = r_busy;
endmodule
